counter_sequencer: RTL and testbench

- Synchronous controller that sequences the 4-bit display counter from the 100 MHz board clock.
- Replaces free-running ripple division with a programmable prescaler that emits a single-cycle tick enable.
- Holds the counter value and runs it up or down, in wrap or one-shot mode, under start/pause/resume/clear commands.
- Sits between the board-level controls and the counter output q; everything is in the clk_100MHz domain.

---
 rtl/counter_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 28 ++
 rtl/counter_sequencer.sv | 124 ++++++++++++
 tb/tb_counter_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encodings and divisor constants for the counter sequencer
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DIV_DEFAULT = 100_000_000;
    localparam int DIV_SIM     = 4;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - programmable divider flagging the last cycle of each tick period
module tick_prescaler #(
    parameter int DIV_WIDTH = 27
) (
    input  logic                 clk_100MHz,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;
    logic                 at_end;

    assign at_end = (cnt == div - DIV_WIDTH'(1));
    // Combinational: the owner registers it so tick lands with the q update.
    assign tick   = run && at_end;

    always_ff @(posedge clk_100MHz) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= at_end ? '0 : cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - up/down wrap/one-shot counter sequenced by a prescaled tick
module counter_sequencer #(
    parameter int WIDTH       = 4,
    parameter int DIV_WIDTH   = 27,
    parameter int DIV_DEFAULT = 100_000_000
) (
    input  logic                 clk_100MHz,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 resume,
    input  logic                 clear,
    input  logic                 dir_up,
    input  logic                 one_shot,
    input  logic [WIDTH-1:0]     load_val,
    input  logic [WIDTH-1:0]     term_val,
    input  logic [DIV_WIDTH-1:0] div_count,
    output logic [WIDTH-1:0]     q,
    output logic                 tick,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state
);
    import counter_pkg::*;

    state_t               state_r, state_n;
    logic [WIDTH-1:0]     q_n, step_val;
    logic                 tick_n, done_n, latch, presc_clr, tick_due;
    logic                 dir_r, os_r;
    logic [WIDTH-1:0]     load_r, term_r;
    logic [DIV_WIDTH-1:0] div_r, div_eff;

    assign div_eff = (div_count == '0) ? DIV_WIDTH'(DIV_DEFAULT) : div_count;
    assign state   = state_r;
    assign busy    = (state_r == ST_RUN) || (state_r == ST_PAUSE);

    tick_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .run        (state_r == ST_RUN),
        .clr        (presc_clr),
        .div        (div_r),
        .tick       (tick_due)
    );

    always_comb begin
        state_n   = state_r;
        q_n       = q;
        tick_n    = 1'b0;
        done_n    = 1'b0;
        latch     = 1'b0;
        presc_clr = 1'b0;
        step_val  = dir_r ? q + WIDTH'(1) : q - WIDTH'(1);
        if (clear) begin
            state_n   = ST_IDLE;
            q_n       = '0;
            presc_clr = 1'b1;
        end else if (start && (state_r == ST_IDLE || state_r == ST_DONE)) begin
            latch     = 1'b1;
            presc_clr = 1'b1;
            q_n       = load_val;
            if (one_shot && load_val == term_val) begin
                state_n = ST_DONE;
                done_n  = 1'b1;
            end else begin
                state_n = ST_RUN;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (tick_due) begin
                        tick_n = 1'b1;
                        if (os_r && step_val == term_r) begin
                            q_n     = term_r;
                            state_n = ST_DONE;
                            done_n  = 1'b1;
                        end else if (!os_r && q == term_r) begin
                            q_n = load_r;
                        end else begin
                            q_n = step_val;
                        end
                    end
                    // A tick due this cycle still completes before pausing.
                    if (state_n == ST_RUN && pause && !resume) begin
                        state_n = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (resume && !pause) begin
                        state_n = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_r <= ST_IDLE;
            q       <= '0;
            tick    <= 1'b0;
            done    <= 1'b0;
            dir_r   <= 1'b0;
            os_r    <= 1'b0;
            load_r  <= '0;
            term_r  <= '0;
            div_r   <= '0;
        end else begin
            state_r <= state_n;
            q       <= q_n;
            tick    <= tick_n;
            done    <= done_n;
            if (latch) begin
                dir_r  <= dir_up;
                os_r   <= one_shot;
                load_r <= load_val;
                term_r <= term_val;
                div_r  <= div_eff;
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - scoreboard bench for counter_sequencer
module tb_counter_sequencer;
    import counter_pkg::*;

    localparam int W  = 4;
    localparam int DW = 27;

    logic          clk_100MHz = 1'b0;
    logic          rst, start, pause, resume, clear, dir_up, one_shot;
    logic [W-1:0]  load_val, term_val;
    logic [DW-1:0] div_count;
    logic [W-1:0]  q;
    logic          tick, busy, done;
    logic [1:0]    state;

    always #5 clk_100MHz = ~clk_100MHz;

    counter_sequencer #(.WIDTH(W), .DIV_WIDTH(DW), .DIV_DEFAULT(7)) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .resume     (resume),
        .clear      (clear),
        .dir_up     (dir_up),
        .one_shot   (one_shot),
        .load_val   (load_val),
        .term_val   (term_val),
        .div_count  (div_count),
        .q          (q),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [3:0] qv;
        logic       t;
        logic       d;
        logic [1:0] st;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic goto_cycle(input int k);
        while (cyc < k) step();
    endtask

    task automatic push(input int c, input logic [3:0] qv, input logic t, input logic d, input logic [1:0] st);
        ev_t e;
        e.c = c; e.qv = qv; e.t = t; e.d = d; e.st = st;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [3:0] l, input logic [3:0] t, input logic up,
                            input logic os, input int dv, output int s);
        step();
        load_val  = l;
        term_val  = t;
        dir_up    = up;
        one_shot  = os;
        div_count = DW'(dv);
        start     = 1'b1;
        s         = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk_100MHz);
            #1;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic clear_at(input int k);
        goto_cycle(k);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_q", q, 0);
        check("clear_state", state, ST_IDLE);
        check("clear_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: cycle=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        int s, r, ok;
        logic [3:0] down_q [6];
        logic [3:0] fast_q [12];
        down_q = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
        fast_q = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd5, 4'd6};

        rst = 1'b1; start = 1'b0; pause = 1'b0; resume = 1'b0; clear = 1'b0;
        dir_up = 1'b0; one_shot = 1'b0; load_val = '0; term_val = '0; div_count = '0;

        fork
            forever begin
                ev_t e;
                @(negedge clk_100MHz);
                if (tick || done) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event: cycle=%0d q=%0d tick=%0d done=%0d state=%0d",
                                 cyc, q, tick, done, state);
                    end else begin
                        e = sb.pop_front();
                        check("ev_cycle", cyc, e.c);
                        check("ev_q", q, e.qv);
                        check("ev_tick", tick, e.t);
                        check("ev_done", done, e.d);
                        check("ev_state", state, e.st);
                    end
                end
            end
        join_none

        // Reset state
        repeat (10) step();
        check("rst_q", q, 0);
        check("rst_state", state, ST_IDLE);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Up-count wrap, div 4; config scrambled mid-run must not matter
        do_start(4'd0, 4'd15, 1'b1, 1'b0, 4, s);
        check("run_busy", busy, 1);
        check("run_q_load", q, 0);
        load_val = 4'd7; term_val = 4'd3; dir_up = 1'b0; one_shot = 1'b1; div_count = DW'(1);
        for (int n = 1; n <= 20; n++) push(s + 1 + 4 * n, 4'(n % 16), 1'b1, 1'b0, ST_RUN);
        drain(200);
        clear_at(s + 81);

        // Down one-shot 9 -> 3, div 2
        do_start(4'd9, 4'd3, 1'b0, 1'b1, 2, s);
        for (int n = 1; n <= 6; n++)
            push(s + 1 + 2 * n, down_q[n-1], 1'b1, n == 6, (n == 6) ? ST_DONE : ST_RUN);
        drain(100);
        ok = 1;
        repeat (100) begin
            step();
            if (q !== 4'd3 || state !== ST_DONE) ok = 0;
        end
        check("done_hold", ok, 1);

        // Pause/resume phase, div 5; start in RUN ignored
        do_start(4'd0, 4'd15, 1'b1, 1'b0, 5, s);
        push(s + 6, 4'd1, 1'b1, 1'b0, ST_RUN);
        drain(50);
        goto_cycle(s + 7);
        start = 1'b1; load_val = 4'd9;
        step();
        start = 1'b0; pause = 1'b1;
        step();
        pause = 1'b0;
        check("pause_state", state, ST_PAUSE);
        check("pause_q", q, 1);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            pause  = (i == 10);
            resume = (i == 10);
            if (q !== 4'd1 || tick !== 1'b0 || state !== ST_PAUSE) ok = 0;
        end
        pause = 1'b0; resume = 1'b0;
        check("pause_hold", ok, 1);
        step();
        resume = 1'b1;
        r = cyc;
        push(r + 3, 4'd2, 1'b1, 1'b0, ST_RUN);
        push(r + 8, 4'd3, 1'b1, 1'b0, ST_PAUSE);
        step();
        resume = 1'b0;
        goto_cycle(r + 7);
        pause = 1'b1;
        step();
        pause = 1'b0;
        drain(50);
        repeat (5) step();
        check("pause_tick_q", q, 3);
        check("pause_tick_state", state, ST_PAUSE);
        clear_at(cyc);

        // clear and start together in IDLE
        step();
        clear = 1'b1; start = 1'b1; load_val = 4'd5;
        step();
        clear = 1'b0; start = 1'b0;
        check("clr_start_state", state, ST_IDLE);
        check("clr_start_q", q, 0);

        // div_count 0 selects the default divisor (7 here)
        do_start(4'd0, 4'd15, 1'b1, 1'b0, 0, s);
        for (int n = 1; n <= 3; n++) push(s + 1 + 7 * n, 4'(n), 1'b1, 1'b0, ST_RUN);
        drain(50);
        clear_at(s + 22);

        // div 1: tick every cycle, wraps 15 -> load 5
        do_start(4'd5, 4'd15, 1'b1, 1'b0, 1, s);
        for (int n = 1; n <= 12; n++) push(s + 1 + n, fast_q[n-1], 1'b1, 1'b0, ST_RUN);
        drain(50);
        clear_at(s + 13);

        // one-shot with load == term: immediate DONE, no tick
        do_start(4'd5, 4'd5, 1'b1, 1'b1, 3, s);
        push(s + 1, 4'd5, 1'b0, 1'b1, ST_DONE);
        drain(20);
        check("imm_done_state", state, ST_DONE);

        // up one-shot 14 -> 1 through 15, 0
        do_start(4'd14, 4'd1, 1'b1, 1'b1, 3, s);
        push(s + 4, 4'd15, 1'b1, 1'b0, ST_RUN);
        push(s + 7, 4'd0, 1'b1, 1'b0, ST_RUN);
        push(s + 10, 4'd1, 1'b1, 1'b1, ST_DONE);
        drain(50);

        // reset mid-run at q == 6
        do_start(4'd0, 4'd15, 1'b1, 1'b0, 2, s);
        for (int n = 1; n <= 6; n++) push(s + 1 + 2 * n, 4'(n), 1'b1, 1'b0, ST_RUN);
        drain(50);
        rst = 1'b1;
        step();
        check("mid_rst_q", q, 0);
        check("mid_rst_state", state, ST_IDLE);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_done", done, 0);
        rst = 1'b0;
        repeat (10) step();
        check("post_rst_state", state, ST_IDLE);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
